// File: rtl/digit_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry_ctrl
// Purpose  : Multi-digit guess entry controller. Per-digit inc/dec buttons
//            edit a live entry. A confirm edge locks the entry into a guess
//            that is offered through a valid/ready handshake. Accepted
//            guesses are counted with saturation.
// Ports    : clk          - system clock, all state on rising edge
//            restart      - asynchronous active-high reset
//            max_digits   - number of enabled digits (difficulty)
//            inc_btn      - per-digit increment buttons (level)
//            dec_btn      - per-digit decrement buttons (level)
//            confirm      - lock-in button (level)
//            guess_ready  - consumer ready for the locked guess
//            entry_digits - live digits, digit i at [i*DIGIT_W +: DIGIT_W]
//            guess_digits - locked guess, same packing
//            guess_valid  - locked guess offered
//            guess_count  - accepted guesses since reset (saturating)
// Config   : DIGIT_AUTOREPEAT_EN - when defined, held buttons auto-repeat
//            after REPEAT_DLY cycles, then every REPEAT_PER cycles.
// Revision : 1.0 - initial release
// ============================================================================
module digit_entry_ctrl #(
   parameter int NUM_DIGITS = 3,
   parameter int DIGIT_W    = 4,
   parameter int MAX_VAL    = 9,
   parameter int CNT_W      = 8,
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000
) (
   input  logic                            clk,
   input  logic                            restart,
   input  logic [$clog2(NUM_DIGITS+1)-1:0] max_digits,
   input  logic [NUM_DIGITS-1:0]           inc_btn,
   input  logic [NUM_DIGITS-1:0]           dec_btn,
   input  logic                            confirm,
   input  logic                            guess_ready,
   output logic [NUM_DIGITS*DIGIT_W-1:0]   entry_digits,
   output logic [NUM_DIGITS*DIGIT_W-1:0]   guess_digits,
   output logic                            guess_valid,
   output logic [CNT_W-1:0]                guess_count
);

   localparam logic [DIGIT_W-1:0] c_MAX     = DIGIT_W'(MAX_VAL);
   localparam logic [CNT_W-1:0]   c_CNT_SAT = '1;

   typedef enum logic [0:0] {
      ST_EDIT  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t                        r_state;
   logic [NUM_DIGITS-1:0]         r_inc_prev;
   logic [NUM_DIGITS-1:0]         r_dec_prev;
   logic                          r_conf_prev;
   // Low for the first cycle after reset so a button already held at
   // release is sampled into the history instead of counting as an edge.
   logic                          r_armed;
   logic [NUM_DIGITS*DIGIT_W-1:0] r_entry;
   logic [NUM_DIGITS*DIGIT_W-1:0] r_guess;
   logic                          r_valid;
   logic [CNT_W-1:0]              r_count;

   logic [NUM_DIGITS-1:0]         w_en;
   logic [NUM_DIGITS-1:0]         w_inc_edge;
   logic [NUM_DIGITS-1:0]         w_dec_edge;
   logic [NUM_DIGITS-1:0]         w_rpt_inc;
   logic [NUM_DIGITS-1:0]         w_rpt_dec;
   logic [NUM_DIGITS-1:0]         w_step_inc;
   logic [NUM_DIGITS-1:0]         w_step_dec;
   logic                          w_conf_edge;
   logic [NUM_DIGITS*DIGIT_W-1:0] w_entry_masked;
   logic [NUM_DIGITS*DIGIT_W-1:0] w_next_digits;

   assign w_inc_edge  = inc_btn & ~r_inc_prev & {NUM_DIGITS{r_armed}};
   assign w_dec_edge  = dec_btn & ~r_dec_prev & {NUM_DIGITS{r_armed}};
   assign w_conf_edge = confirm & ~r_conf_prev & r_armed;

   assign w_step_inc  = (w_inc_edge | w_rpt_inc) & w_en;
   assign w_step_dec  = (w_dec_edge | w_rpt_dec) & w_en;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [DIGIT_W-1:0] w_cur;
         logic [DIGIT_W-1:0] w_nxt;

         // max_digits above NUM_DIGITS simply enables every digit.
         assign w_en[gi] = (32'(max_digits) > gi);
         assign w_cur    = r_entry[gi*DIGIT_W +: DIGIT_W];
         assign w_entry_masked[gi*DIGIT_W +: DIGIT_W] = w_en[gi] ? w_cur : '0;

         // Opposing steps on the same digit cancel.
         always_comb begin
            w_nxt = w_cur;
            if (!w_en[gi]) begin
               w_nxt = '0;
            end else if (w_step_inc[gi] && !w_step_dec[gi]) begin
               w_nxt = (w_cur >= c_MAX) ? '0 : w_cur + 1'b1;
            end else if (w_step_dec[gi] && !w_step_inc[gi]) begin
               w_nxt = ((w_cur == '0) || (w_cur > c_MAX)) ? c_MAX : w_cur - 1'b1;
            end
         end

         assign w_next_digits[gi*DIGIT_W +: DIGIT_W] = w_nxt;
      end
   endgenerate

   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         r_state     <= ST_EDIT;
         r_inc_prev  <= '0;
         r_dec_prev  <= '0;
         r_conf_prev <= 1'b0;
         r_armed     <= 1'b0;
         r_entry     <= '0;
         r_guess     <= '0;
         r_valid     <= 1'b0;
         r_count     <= '0;
      end else begin
         // History is tracked in every state so nothing held through OFFER
         // looks like a fresh press on return to EDIT.
         r_inc_prev  <= inc_btn;
         r_dec_prev  <= dec_btn;
         r_conf_prev <= confirm;
         r_armed     <= 1'b1;
         case (r_state)
            ST_EDIT: begin
               if (w_conf_edge) begin
                  // Lock the pre-update entry; button edges this cycle are lost.
                  r_guess <= w_entry_masked;
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end else begin
                  r_entry <= w_next_digits;
               end
            end
            ST_OFFER: begin
               if (r_valid && guess_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ST_EDIT;
                  if (r_count != c_CNT_SAT) begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            default: r_state <= ST_EDIT;
         endcase
      end
   end

`ifdef DIGIT_AUTOREPEAT_EN
   localparam int c_RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

   // r_rpt_cnt counts cycles since the last step; zero means disarmed, so a
   // button still held when returning from OFFER never starts repeating.
   logic [c_RPT_W-1:0]    r_rpt_cnt;
   logic                  r_rpt_phase;
   logic [NUM_DIGITS-1:0] w_inc_held;
   logic [NUM_DIGITS-1:0] w_dec_held;
   logic                  w_new_edge;
   logic                  w_any_held;
   logic                  w_rpt_active;
   logic                  w_rpt_fire;

   assign w_inc_held   = inc_btn & r_inc_prev & w_en;
   assign w_dec_held   = dec_btn & r_dec_prev & w_en;
   assign w_new_edge   = |((w_inc_edge | w_dec_edge) & w_en);
   assign w_any_held   = |(w_inc_held | w_dec_held);
   assign w_rpt_active = (r_state == ST_EDIT) && !w_conf_edge;
   assign w_rpt_fire   = w_rpt_active && !w_new_edge && w_any_held &&
                         (r_rpt_cnt != '0) &&
                         (r_rpt_phase ? (r_rpt_cnt == c_RPT_W'(REPEAT_PER))
                                      : (r_rpt_cnt == c_RPT_W'(REPEAT_DLY)));
   assign w_rpt_inc    = w_rpt_fire ? w_inc_held : '0;
   assign w_rpt_dec    = w_rpt_fire ? w_dec_held : '0;

   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         r_rpt_cnt   <= '0;
         r_rpt_phase <= 1'b0;
      end else if (!w_rpt_active || (!w_new_edge && !w_any_held)) begin
         r_rpt_cnt   <= '0;
         r_rpt_phase <= 1'b0;
      end else if (w_new_edge) begin
         r_rpt_cnt   <= c_RPT_W'(1);
         r_rpt_phase <= 1'b0;
      end else if (r_rpt_cnt != '0) begin
         if (w_rpt_fire) begin
            r_rpt_cnt   <= c_RPT_W'(1);
            r_rpt_phase <= 1'b1;
         end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
         end
      end
   end
`else
   logic w_unused_rpt;
   assign w_rpt_inc    = '0;
   assign w_rpt_dec    = '0;
   assign w_unused_rpt = ^{REPEAT_DLY, REPEAT_PER};
`endif

   assign entry_digits = r_entry;
   assign guess_digits = r_guess;
   assign guess_valid  = r_valid;
   assign guess_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_entry_ctrl
// Purpose  : Self-checking bench for digit_entry_ctrl. Stimulus pushes
//            expected values into a scoreboard; a negedge monitor compares
//            them and checks every accepted guess on its handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_entry_ctrl;

   localparam int K_E = 0;  // entry_digits
   localparam int K_G = 1;  // guess_digits
   localparam int K_V = 2;  // guess_valid
   localparam int K_C = 3;  // guess_count

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } chk_t;

   typedef struct {
      logic [11:0] guess;
      logic [1:0]  cnt;
   } xfer_t;

   logic        clk = 1'b0;
   logic        restart;
   logic [1:0]  max_digits;
   logic [2:0]  inc_btn;
   logic [2:0]  dec_btn;
   logic        confirm;
   logic        guess_ready;
   logic [11:0] entry_digits;
   logic [11:0] guess_digits;
   logic        guess_valid;
   logic [1:0]  guess_count;

   int    cyc = 0;
   int    n_total = 0;
   int    n_pass = 0;
   chk_t  chk_q[$];
   xfer_t xfer_q[$];

   digit_entry_ctrl #(
      .NUM_DIGITS(3), .DIGIT_W(4), .MAX_VAL(9), .CNT_W(2),
      .REPEAT_DLY(4), .REPEAT_PER(2)
   ) dut (
      .clk(clk), .restart(restart), .max_digits(max_digits),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .confirm(confirm),
      .guess_ready(guess_ready), .entry_digits(entry_digits),
      .guess_digits(guess_digits), .guess_valid(guess_valid),
      .guess_count(guess_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   function automatic logic [31:0] actual(int kind);
      case (kind)
         K_E:     return 32'(entry_digits);
         K_G:     return 32'(guess_digits);
         K_V:     return 32'(guess_valid);
         default: return 32'(guess_count);
      endcase
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expect a value at the negedge 'dly' cycles after the current one.
   task automatic expect_at(int dly, int kind, logic [31:0] v, string nm);
      chk_t it;
      it.cyc  = cyc + dly;
      it.kind = kind;
      it.val  = v;
      it.name = nm;
      chk_q.push_back(it);
   endtask

   task automatic expect_xfer(logic [11:0] g, logic [1:0] c);
      xfer_t x;
      x.guess = g;
      x.cnt   = c;
      xfer_q.push_back(x);
   endtask

   // Monitor: compares accepted guesses on handshake and due scoreboard items.
   always @(negedge clk) begin
      chk_t  it;
      xfer_t x;
      if (guess_valid && guess_ready) begin
         if (xfer_q.size() == 0) begin
            check("xfer_unexpected", 32'(guess_valid), 32'(0));
         end else begin
            x = xfer_q.pop_front();
            check("xfer_guess", 32'(guess_digits), 32'(x.guess));
            check("xfer_count_before", 32'(guess_count), 32'(x.cnt));
         end
      end
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
         it = chk_q.pop_front();
         check(it.name, actual(it.kind), it.val);
      end
   end

   initial begin
      restart = 1'b1; max_digits = 2'd3; inc_btn = '0; dec_btn = '0;
      confirm = 1'b0; guess_ready = 1'b0;
      tick(); tick();
      expect_at(0, K_E, 0, "rst_entry");
      expect_at(0, K_G, 0, "rst_guess");
      expect_at(0, K_V, 0, "rst_valid");
      expect_at(0, K_C, 0, "rst_count");
      tick();
      restart = 1'b0;
      tick(); tick();

      // Increment wrap on digit 0.
      for (int n = 1; n <= 10; n++) begin
         expect_at(1, K_E, 32'(n % 10), "inc_wrap_d0");
         inc_btn[0] = 1'b1; tick(); inc_btn[0] = 1'b0; tick();
      end

      // Decrement wrap, inc+dec cancel, independent digits.
      expect_at(1, K_E, 32'h090, "dec_wrap_cancel");
      dec_btn[1] = 1'b1; inc_btn[2] = 1'b1; dec_btn[2] = 1'b1; tick();
      dec_btn = '0; inc_btn = '0; tick();
      expect_at(1, K_E, 32'h191, "multi_digit_inc");
      inc_btn[0] = 1'b1; inc_btn[2] = 1'b1; tick(); inc_btn = '0; tick();
      expect_at(1, K_E, 32'h101, "inc_wrap_d1");
      inc_btn[1] = 1'b1; tick(); inc_btn = '0; tick();
      expect_at(1, K_E, 32'h000, "multi_digit_dec");
      dec_btn[0] = 1'b1; dec_btn[2] = 1'b1; tick(); dec_btn = '0; tick();

      // Entry 4,0,0 then restrict to one digit.
      for (int n = 1; n <= 4; n++) begin
         expect_at(1, K_E, 32'(n), "build_d0");
         inc_btn[0] = 1'b1; tick(); inc_btn[0] = 1'b0; tick();
      end
      max_digits = 2'd1;
      tick();
      expect_at(1, K_E, 32'h004, "disabled_ignore");
      inc_btn[1] = 1'b1; inc_btn[2] = 1'b1; tick(); inc_btn = '0; tick();

      // Confirm, with a same-cycle inc that must be dropped.
      expect_at(1, K_E, 32'h004, "confirm_drop_inc");
      expect_at(1, K_V, 1, "confirm_valid");
      expect_at(1, K_G, 32'h004, "confirm_guess");
      expect_xfer(12'h004, 2'd0);
      confirm = 1'b1; inc_btn[0] = 1'b1; tick();
      confirm = 1'b0; inc_btn[0] = 1'b0; tick();

      // Offer held with ready low; button edges ignored.
      for (int k = 0; k < 5; k++) begin
         inc_btn[0] = ((k % 2) == 0);
         expect_at(0, K_G, 32'h004, "offer_guess_hold");
         expect_at(0, K_V, 1, "offer_valid_hold");
         expect_at(0, K_E, 32'h004, "offer_entry_hold");
         tick();
      end
      // inc_btn[0] stays high across the handshake.
      guess_ready = 1'b1;
      expect_at(1, K_V, 0, "xfer_valid_low");
      expect_at(1, K_C, 1, "xfer_count1");
      tick();
      guess_ready = 1'b0;
      tick(); tick();
      expect_at(0, K_E, 32'h004, "held_across_return");
      inc_btn[0] = 1'b0;
      tick();
      guess_ready = 1'b1;
      expect_at(2, K_C, 1, "ready_no_valid");
      tick(); tick();
      guess_ready = 1'b0;

      // max_digits = 0 forces every digit to zero.
      max_digits = 2'd0;
      expect_at(1, K_E, 0, "all_disabled");
      tick();
      max_digits = 2'd3;
      tick();
      expect_at(0, K_E, 0, "reenable_zero");
      tick();

      // Count saturation at 3.
      expect_at(1, K_E, 32'h010, "pre_sat_entry");
      inc_btn[1] = 1'b1; tick(); inc_btn = '0; tick();
      for (int j = 0; j < 3; j++) begin
         expect_xfer(12'h010, (j == 0) ? 2'd1 : ((j == 1) ? 2'd2 : 2'd3));
         confirm = 1'b1; tick();
         confirm = 1'b0; guess_ready = 1'b1;
         expect_at(1, K_C, (j == 0) ? 32'd2 : 32'd3, "count_sat");
         expect_at(1, K_V, 0, "sat_valid_low");
         tick();
         guess_ready = 1'b0;
         tick();
      end

      // Asynchronous restart mid-offer.
      confirm = 1'b1; tick();
      confirm = 1'b0; inc_btn[0] = 1'b1; tick();
      #2;
      restart = 1'b1;
      #1;
      check("async_valid", 32'(guess_valid), 32'(0));
      check("async_entry", 32'(entry_digits), 32'(0));
      check("async_guess", 32'(guess_digits), 32'(0));
      check("async_count", 32'(guess_count), 32'(0));
      guess_ready = 1'b1;
      tick(); tick();
      restart = 1'b0;
      tick();
      expect_at(0, K_E, 0, "held_through_reset");
      expect_at(0, K_C, 0, "post_reset_count");
      tick(); tick();
      expect_at(0, K_E, 0, "held_through_reset2");
      inc_btn[0] = 1'b0; guess_ready = 1'b0;
      tick();
      expect_at(1, K_E, 32'h001, "first_edge_after_reset");
      inc_btn[0] = 1'b1; tick(); inc_btn[0] = 1'b0; tick();

      // Ten-cycle hold on digit 0.
      inc_btn[0] = 1'b1;
      repeat (10) tick();
      inc_btn[0] = 1'b0;
`ifdef DIGIT_AUTOREPEAT_EN
      expect_at(1, K_E, 32'h005, "autorepeat_hold");
`else
      expect_at(1, K_E, 32'h002, "single_step_hold");
`endif
      tick(); tick();

      for (int k = 0; k < 20 && chk_q.size() > 0; k++) tick();
      while (chk_q.size() > 0) begin
         chk_t it;
         it = chk_q.pop_front();
         n_total++;
         $display("FAIL %s: actual=unchecked required=checked", it.name);
      end
      while (xfer_q.size() > 0) begin
         void'(xfer_q.pop_front());
         n_total++;
         $display("FAIL xfer_missing: actual=no_handshake required=handshake");
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
